// File: rtl/div8_seq_if.sv
// Operand/result bundle for the sequential divider.
// The requester drives start/A/B. The divider returns busy/done and the held result fields.
interface div8_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             div_by_zero;

    // Requester side: issues operands and observes completion.
    modport master (
        output start, A, B,
        input  busy, done, quot, rem, div_by_zero
    );

    // Divider side: accepts operands and publishes results.
    modport slave (
        input  start, A, B,
        output busy, done, quot, rem, div_by_zero
    );
endinterface

// File: rtl/div8_seq.sv
// Multi-cycle unsigned restoring divider.
// Each clock performs one shift/subtract step. A result takes WIDTH steps,
// plus one presentation cycle in which done pulses. A zero divisor skips the
// steps: the result is quot = all ones, rem = dividend, and the
// div_by_zero flag is set.
module div8_seq #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    div8_seq_if.slave   bus
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Restoring step: subtract the divisor from the shifted partial
    // remainder at WIDTH+1 bits. The MSB of the result is the borrow.
    function automatic logic [WIDTH:0] trial_sub(
        input logic [WIDTH:0]   shifted,
        input logic [WIDTH-1:0] divisor
    );
        return shifted - {1'b0, divisor};
    endfunction

    // Control and published-result state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    // Working datapath: partial remainder, dividend/quotient shifter, divisor
    logic [WIDTH:0]   prem_q,  prem_d;
    logic [WIDTH-1:0] dvd_q,   dvd_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;

    // Single-step results, shared by every CALC cycle
    logic [WIDTH:0]   step_shift;
    logic [WIDTH:0]   step_trial;
    logic             step_qbit;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // One shift/subtract step computed from the current working registers
    always_comb begin
        step_shift = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        step_trial = trial_sub(step_shift, dvs_q);
        step_qbit  = ~step_trial[WIDTH];
        step_rem   = step_qbit ? step_trial : step_shift;
        step_quo   = {dvd_q[WIDTH-2:0], step_qbit};
    end

    // Next-state and datapath update. Results are published only on DONE entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        prem_d  = prem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d  = bus.A;
                    dvs_d  = bus.B;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (bus.B == '0) begin
                        // Nothing to iterate: publish the zero-divisor result now
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = bus.A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                prem_d = step_rem;
                dvd_d  = step_quo;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    // The final step's outputs are the result. The remainder
                    // is below the divisor, so its top bit is always zero.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    quot_d  = step_quo;
                    rem_d   = step_rem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end

            S_DONE: begin
                // start is ignored here. A held request is taken on the next IDLE edge.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and result registers. Reset clears them and aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working registers have no reset. They are always loaded on accept before use.
    always_ff @(posedge clk) begin
        prem_q <= prem_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.quot        = quot_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Testbench for div8_seq. It applies table vectors, corner-case sequences,
// sweeps and random operands, and compares against an arithmetic reference.
module tb_div8_seq;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    div8_seq_if #(.WIDTH(8)) bus ();

    div8_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic z);
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issue one request from IDLE and check latency, result, held outputs and return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic ez,
                          input bit keep_start, input logic [7:0] nxt_a, input logic [7:0] nxt_b);
        logic [7:0] pq, pr;
        logic       pz;
        int         n;
        bit         got;
        bit         held;
        pq = bus.quot;
        pr = bus.rem;
        pz = bus.div_by_zero;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        if (!keep_start) bus.start = 1'b0;
        bus.A = nxt_a;
        bus.B = nxt_b;
        n    = 0;
        got  = 1'b0;
        held = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) got = 1'b1;
            else if (bus.quot !== pq || bus.rem !== pr || bus.div_by_zero !== pz || bus.busy !== 1'b1)
                held = 1'b0;
        end
        check({tag, " latency"}, n, (b == 8'd0) ? 1 : 9);
        check({tag, " quot"}, bus.quot, eq);
        check({tag, " rem"}, bus.rem, er);
        check({tag, " dbz"}, bus.div_by_zero, ez);
        check({tag, " held while busy"}, held, 1);
        @(negedge clk);
        check({tag, " done one pulse"}, bus.done, 0);
        check({tag, " busy after"}, bus.busy, 0);
        check({tag, " quot kept"}, bus.quot, eq);
    endtask

    task automatic run_rand(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] q, r;
        logic       z;
        ref_div(a, b, q, r, z);
        run_op(tag, a, b, q, r, z, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        int  n;
        bit  got;
        bit  quiet;
        n_checks  = 0;
        n_fail    = 0;
        bus.start = 1'b0;
        bus.A     = 8'd0;
        bus.B     = 8'd0;
        rst_n     = 1'b0;

        vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[2]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[3]  = '{8'd3,   8'd200, 8'd0,   8'd3,   1'b0};
        vecs[4]  = '{8'd77,  8'd0,   8'hFF,  8'd77,  1'b1};
        vecs[5]  = '{8'd77,  8'd77,  8'd1,   8'd0,   1'b0};
        vecs[6]  = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
        vecs[7]  = '{8'd50,  8'd3,   8'd16,  8'd2,   1'b0};
        vecs[8]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[9]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};
        vecs[10] = '{8'd255, 8'd0,   8'hFF,  8'd255, 1'b1};
        vecs[11] = '{8'd254, 8'd127, 8'd2,   8'd0,   1'b0};
        vecs[12] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0};
        vecs[13] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset quot", bus.quot, 0);
        check("reset rem", bus.rem, 0);
        check("reset dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;

        // Table vectors, back to back
        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                   1'b0, 8'($urandom), 8'($urandom));

        // start held through busy: the second request waits for IDLE
        run_op("hold first", 8'd200, 8'd9, 8'd22, 8'd2, 1'b0, 1'b1, 8'd1, 8'd1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        bus.start = 1'b0;
        check("hold second latency", n, 9);
        check("hold second quot", bus.quot, 1);
        check("hold second rem", bus.rem, 0);
        @(negedge clk);
        check("hold idle", bus.busy, 0);

        // Held start with a zero divisor gives one result every 2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd9;
        bus.B     = 8'd0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        bus.start = 1'b0;
        check("dbz stream count", n, 4);
        @(negedge clk);

        // Reset in the middle of a calculation
        run_op("pre reset", 8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'd50;
        bus.B     = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset busy", bus.busy, 0);
        check("midreset done", bus.done, 0);
        check("midreset quot", bus.quot, 0);
        check("midreset rem", bus.rem, 0);
        check("midreset dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        check("midreset no done", quiet, 1);
        run_op("after reset", 8'd50, 8'd3, 8'd16, 8'd2, 1'b0, 1'b0, 8'd0, 8'd0);

        // Sweeps: every divisor, and every dividend against edge divisors
        for (int b = 0; b < 256; b++)
            run_rand("sweepB", 8'($urandom), 8'(b));
        for (int a = 0; a < 256; a++) begin
            run_rand("sweepA0", 8'(a), 8'd0);
            run_rand("sweepA1", 8'(a), 8'd1);
            run_rand("sweepAff", 8'(a), 8'd255);
            run_rand("sweepAr", 8'(a), 8'($urandom_range(1, 255)));
        end

        // Random operands
        for (int k = 0; k < 1200; k++)
            run_rand("rand", 8'($urandom), 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
